// File: rtl/mem_router.sv
// mem_router: decodes host data-port requests onto N_SLV base/mask windows,
// tracks one outstanding access and answers unmapped, misaligned or timed-out accesses with an error.
module mem_router #(
  parameter int                  MEM_W    = 32,
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*32-1:0] SLV_MASK = '0,
  parameter int                  TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_req_i,
  output logic                   host_gnt_o,
  input  logic [31:0]            host_addr_i,
  input  logic                   host_we_i,
  input  logic [MEM_W/8-1:0]     host_be_i,
  input  logic [MEM_W-1:0]       host_wdata_i,
  output logic                   host_rvalid_o,
  output logic                   host_err_o,
  output logic [MEM_W-1:0]       host_rdata_o,
  output logic [N_SLV-1:0]       slv_req_o,
  output logic [31:0]            slv_addr_o,
  output logic                   slv_we_o,
  output logic [MEM_W/8-1:0]     slv_be_o,
  output logic [MEM_W-1:0]       slv_wdata_o,
  input  logic [N_SLV-1:0]       slv_rvalid_i,
  input  logic [N_SLV-1:0]       slv_err_i,
  input  logic [N_SLV*MEM_W-1:0] slv_rdata_i
);
  localparam int BW = MEM_W / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = N_SLV > 1 ? $clog2(N_SLV) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d, dec_idx;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d, we_q, we_d, dec_hit, mapped, rv_sel, timeout;
  logic [MEM_W-1:0]  rdata_q, rdata_d, wdata_q, wdata_d;
  logic [31:0]       addr_q, addr_d;
  logic [BW-1:0]     be_q, be_d;
  // Iterating downwards lets the lowest matching window win.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--)
      if ((host_addr_i & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        dec_hit = 1'b1;
        dec_idx = SW'(i);
      end
  end
  assign mapped  = dec_hit && ((host_addr_i & 32'(BW - 1)) == 32'd0);
  assign rv_sel  = slv_rvalid_i[sel_q];
  // Counter is 1 in the first WAIT cycle, so the comparison looks one count ahead.
  assign timeout = int'(cnt_q) + 1 >= TIMEOUT;
  always_ff @(posedge clk)
    state_q <= !rst_n ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host_req_i) state_d = mapped ? ISSUE : RESP;
      ISSUE:   state_d = rv_sel ? RESP : WAIT;
      WAIT:    if (rv_sel || timeout) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = state_q == ISSUE ? CW'(1) : state_q == WAIT ? cnt_q + 1'b1 : cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && host_req_i) begin
      addr_d  = host_addr_i;
      we_d    = host_we_i;
      be_d    = host_be_i;
      wdata_d = host_wdata_i;
      sel_d   = dec_idx;
      err_d   = mapped ? err_q : 1'b1;
      rdata_d = mapped ? rdata_q : '0;
    end else if ((state_q == ISSUE || state_q == WAIT) && rv_sel) begin
      err_d   = slv_err_i[sel_q];
      rdata_d = we_q ? '0 : slv_rdata_i[MEM_W*sel_q +: MEM_W];
    end else if (state_q == WAIT && timeout) begin
      err_d   = 1'b1;
      rdata_d = '0;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  always_comb begin
    host_gnt_o    = state_q == IDLE && rst_n;
    host_rvalid_o = state_q == RESP;
    slv_req_o     = state_q == ISSUE ? N_SLV'(1) << sel_q : '0;
  end
  assign host_err_o   = err_q;
  assign host_rdata_o = rdata_q;
  assign slv_addr_o   = addr_q;
  assign slv_we_o     = we_q;
  assign slv_be_o     = be_q;
  assign slv_wdata_o  = wdata_q;
endmodule

// File: doc/mem_router.md
# mem_router

Parametrised memory-request router between the Vicuna/Ibex data port and N_SLV memory-mapped targets (digital timer, GPIO bank, UART, SRAM, …). Each request is decoded against per-target base/mask windows, forwarded to exactly one target, and its response is returned to the host. Unmapped, misaligned and timed-out accesses are answered with an error response. This block replaces the fixed four-way decoder and adds outstanding-request tracking, a timeout and error generation.

## Interface
- MEM_W, 32: data bus width in bits; must be a power of two, at least 8.
- N_SLV, 4: number of targets; at least 1.
- SLV_BASE, {N_SLV{32'h0}}: packed N_SLV×32 base addresses; target i uses bits [32*i +: 32].
- SLV_MASK, {N_SLV{32'h0}}: packed N_SLV×32 masks. Target i matches when (addr & MASK_i) == (BASE_i & MASK_i).
- TIMEOUT, 255: cycles to wait for a target response; at least 1.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- host_req_i  in  1  host request valid.
- host_gnt_o  out  1  request accepted this cycle. Equals (state == IDLE) && rst_n.
- host_addr_i  in  32  byte address.
- host_we_i  in  1  1 = write, 0 = read.
- host_be_i  in  MEM_W/8  byte enables.
- host_wdata_i  in  MEM_W  write data.
- host_rvalid_o  out  1  one-cycle response strobe; issued for reads and writes.
- host_err_o  out  1  error qualifier, valid when host_rvalid_o is 1.
- host_rdata_o  out  MEM_W  read data, valid when host_rvalid_o is 1.
- slv_req_o  out  N_SLV  one-hot request pulse.
- slv_addr_o  out  32  registered address, shared by all targets.
- slv_we_o  out  1  registered write enable, shared.
- slv_be_o  out  MEM_W/8  registered byte enables, shared.
- slv_wdata_o  out  MEM_W  registered write data, shared.
- slv_rvalid_i  in  N_SLV  per-target response strobe.
- slv_err_i  in  N_SLV  per-target error qualifier.
- slv_rdata_i  in  N_SLV×MEM_W  per-target read data; target i uses bits [MEM_W*i +: MEM_W].

## Operation
- Only one request is in flight at a time. The state machine has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE.** When host_req_i && host_gnt_o:
  - Capture addr, we, be and wdata into the slv_* registers.
  - Decode the address. If several windows match, the lowest index wins; store that index as sel.
  - Go to RESP with err = 1 and rdata = 0 if the access is unmapped (no window matches) or misaligned (addr[$clog2(MEM_W/8)-1:0] != 0). No target request is issued in this case.
  - Otherwise go to ISSUE.
- **ISSUE.** slv_req_o = one-hot(sel) for exactly this cycle. Clear the timeout counter to 1.
  - If slv_rvalid_i[sel] is 1, capture err and rdata and go to RESP.
  - Otherwise go to WAIT.
- **WAIT.** The counter increments each cycle; its width is $clog2(TIMEOUT+1).
  - If slv_rvalid_i[sel] is 1, capture slv_err_i[sel], and capture slv_rdata_i[sel] for reads or 0 for writes; go to RESP.
  - Otherwise, if the counter equals TIMEOUT, go to RESP with err = 1 and rdata = 0.
  - If rvalid and timeout occur in the same cycle, the rvalid is taken (no error).
- **RESP.** host_rvalid_o = 1 for one cycle, with the captured err and rdata. Return to IDLE.
- slv_rvalid_i bits from non-selected targets are ignored in every state.
- slv_rvalid_i[sel] is ignored in IDLE and RESP. This discards late responses that arrive after a timeout.
- Reset values, applied while rst_n is low at a clock edge:
  - state = IDLE.
  - slv_req_o, slv_addr_o, slv_we_o, slv_be_o, slv_wdata_o = 0.
  - host_rvalid_o, host_err_o, host_rdata_o = 0.
  - Counter and sel = 0.
  - host_gnt_o is 0 whenever rst_n is low.
- Reset asserted mid-transaction abandons the transaction; no response is ever given for it.

## Timing
- Cycle 0 is the accept cycle (host_req_i && host_gnt_o).
- Mapped access: slv_req_o is high in cycle 1.
  - A target answering in cycle 1+k gives host_rvalid_o in cycle 2+k.
  - Minimum latency is 2 cycles.
- Unmapped or misaligned access: host_rvalid_o with err = 1 in cycle 1.
- Timeout: with no target response, host_rvalid_o with err = 1 in cycle TIMEOUT+1.
- host_gnt_o is low from cycle 1 through the RESP cycle. The next accept is possible in the cycle after RESP, so peak throughput is one request per 3 cycles.
- host_rdata_o and host_err_o hold their last values outside RESP; the bench only checks them while host_rvalid_o is 1.

## Test plan
- **Read routing.** N_SLV=4, windows at 0x10/0x10, 0x20/0x20, 0x30/0x30, 0x8000_0000/0x8000_0000 (each window's BASE/MASK pair in order). Read 0x20; target 1 returns 0xDEADBEEF in the ISSUE cycle → slv_req_o = 4'b0010 in cycle 1; host_rvalid_o = 1, err = 0, rdata = 0xDEADBEEF in cycle 2.
- **Write with delayed response.** Write 0x8000_0004, be = 4'b0011, wdata = 0x1234_5678; target 3 responds 5 cycles after its request → slv_be_o = 4'b0011, slv_wdata_o = 0x1234_5678; host_rvalid_o in cycle 7, rdata = 0, err = 0.
- **Unmapped and misaligned.** Read 0x4 (no window), then read 0x22 → each gets host_rvalid_o = 1, err = 1 in cycle 1; slv_req_o stays 0 throughout.
- **Timeout and late response.** TIMEOUT=16, target 0 silent → err response in cycle 17. The target then asserts rvalid in cycle 18 → ignored; a following request to target 1 completes normally.
- **Priority and arbitration corner cases.**
  - Overlapping windows 0 and 1 both match → target 0 is selected.
  - rvalid arrives in the same cycle the counter reaches TIMEOUT → err = 0, data is passed through.
  - Spurious slv_rvalid_i[2] while sel = 1 → ignored.
- **Reset mid-transaction.** Drive rst_n low during WAIT → all outputs are 0 after the edge and no host_rvalid_o is produced. After rst_n rises, a new request is granted immediately.
